// File: rtl/serial_adder_if.sv
// serial_adder_if: start/done operand and result bundle for serial_adder_seq (sub present with SERIAL_ADDER_SUB_EN)
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
`ifdef SERIAL_ADDER_SUB_EN
  modport master(output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave(input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
  modport master(output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave(input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif
endinterface

// File: rtl/serial_adder_seq.sv
// serial_adder_seq: bit-serial WIDTH-bit adder, one full-adder cell reused per cycle; SERIAL_ADDER_SUB_EN adds subtract mode
module serial_adder_seq #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  serial_adder_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] ra, rb, b_in;
  logic [WIDTH-2:0] rh;
  logic [WIDTH-1:0] nr;
  logic [CW-1:0] cnt;
  logic c, c_n, c_in, s, last, load, neg;
`ifdef SERIAL_ADDER_SUB_EN
  assign neg = bus.sub;
`else
  assign neg = 1'b0;
`endif
  // subtraction is a + ~b + 1, so only the load path differs
  assign b_in = neg ? ~bus.b : bus.b;
  assign c_in = neg | bus.cin;
  assign nr = {s, rh};
  always_comb begin
    s = ra[0] ^ rb[0] ^ c;
    c_n = (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));
    last = cnt == CW'(WIDTH - 1);
    load = state != SHIFT && bus.start;
    state_n = state == SHIFT ? (last ? DONE : SHIFT) : (bus.start ? SHIFT : IDLE);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state <= state_n;
      bus.busy <= state_n == SHIFT;
      bus.done <= state_n == DONE;
    end
  end
  // rh keeps the WIDTH-1 most recent sum bits; the final bit completes the word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra <= '0;
      rb <= '0;
      rh <= '0;
      c <= 1'b0;
      cnt <= '0;
      bus.sum <= '0;
      bus.cout <= 1'b0;
      bus.ovf <= 1'b0;
    end else if (load) begin
      ra <= bus.a;
      rb <= b_in;
      c <= c_in;
      cnt <= '0;
    end else if (state == SHIFT) begin
      ra <= ra >> 1;
      rb <= rb >> 1;
      rh <= nr[WIDTH-1:1];
      c <= c_n;
      cnt <= cnt + 1'b1;
      if (last) begin
        bus.sum <= nr;
        bus.cout <= c_n;
        bus.ovf <= c ^ c_n;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_seq.sv
// tb_serial_adder_seq: directed checks of serial_adder_seq at WIDTH 8, 2 and 16
module tb_serial_adder_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vec = 0;
  int bad = 0;
  serial_adder_if #(8) m8();
  serial_adder_if #(2) m2();
  serial_adder_if #(16) m16();
  serial_adder_seq #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(m8));
  serial_adder_seq #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(m2));
  serial_adder_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(m16));
  always #5 clk = ~clk;

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic ci, output int lat, output int bc);
    m8.a = a; m8.b = b; m8.cin = ci; m8.start = 1'b1;
    @(negedge clk);
    m8.start = 1'b0;
    lat = 0;
    bc = m8.busy ? 1 : 0;
    while (!m8.done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (m8.busy) bc++;
    end
  endtask

  task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic ci, output int lat);
    m2.a = a; m2.b = b; m2.cin = ci; m2.start = 1'b1;
    @(negedge clk);
    m2.start = 1'b0;
    lat = 0;
    while (!m2.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic ci, output int lat);
    m16.a = a; m16.b = b; m16.cin = ci; m16.start = 1'b1;
    @(negedge clk);
    m16.start = 1'b0;
    lat = 0;
    while (!m16.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    vec++;
    if ({m8.busy, m8.done, m8.cout, m8.ovf, m8.sum} !== 12'h0) begin
      bad++; $display("FAIL reset_w8 got %h want 000", {m8.busy, m8.done, m8.cout, m8.ovf, m8.sum});
    end
    vec++;
    if ({m16.busy, m16.done, m16.cout, m16.ovf, m16.sum} !== 20'h0) begin
      bad++; $display("FAIL reset_w16 got %h want 00000", {m16.busy, m16.done, m16.cout, m16.ovf, m16.sum});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bc;
    op8(8'h5A, 8'h3C, 1'b0, lat, bc);
    vec++;
    if (lat !== 8) begin bad++; $display("FAIL basic_latency got %0d want 8", lat); end
    vec++;
    if (bc !== 8) begin bad++; $display("FAIL basic_busy_cycles got %0d want 8", bc); end
    vec++;
    if ({m8.busy, m8.sum, m8.cout, m8.ovf} !== {1'b0, 8'h96, 1'b0, 1'b1}) begin
      bad++; $display("FAIL basic_result got busy=%b sum=%h cout=%b ovf=%b want busy=0 sum=96 cout=0 ovf=1", m8.busy, m8.sum, m8.cout, m8.ovf);
    end
    @(negedge clk);
    vec++;
    if ({m8.done, m8.sum} !== {1'b0, 8'h96}) begin
      bad++; $display("FAIL basic_done_pulse got done=%b sum=%h want done=0 sum=96", m8.done, m8.sum);
    end
  endtask

  task automatic test_wrap;
    int lat, bc;
    op8(8'hFF, 8'h01, 1'b0, lat, bc);
    vec++;
    if ({m8.sum, m8.cout, m8.ovf} !== {8'h00, 1'b1, 1'b0}) begin
      bad++; $display("FAIL wrap_ff_01 got sum=%h cout=%b ovf=%b want sum=00 cout=1 ovf=0", m8.sum, m8.cout, m8.ovf);
    end
    op8(8'h00, 8'h00, 1'b1, lat, bc);
    vec++;
    if ({m8.sum, m8.cout, m8.ovf} !== {8'h01, 1'b0, 1'b0}) begin
      bad++; $display("FAIL wrap_cin got sum=%h cout=%b ovf=%b want sum=01 cout=0 ovf=0", m8.sum, m8.cout, m8.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int l1, l2, bc;
    op8(8'h01, 8'h02, 1'b0, l1, bc);
    vec++;
    if (m8.sum !== 8'h03) begin bad++; $display("FAIL b2b_first got %h want 03", m8.sum); end
    op8(8'h40, 8'h40, 1'b0, l2, bc);
    vec++;
    if (l2 + 1 !== 9) begin bad++; $display("FAIL b2b_spacing got %0d want 9", l2 + 1); end
    vec++;
    if ({m8.sum, m8.cout, m8.ovf} !== {8'h80, 1'b0, 1'b1}) begin
      bad++; $display("FAIL b2b_second got sum=%h cout=%b ovf=%b want sum=80 cout=0 ovf=1", m8.sum, m8.cout, m8.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored_start;
    int lat = 0;
    m8.a = 8'h11; m8.b = 8'h22; m8.cin = 1'b0; m8.start = 1'b1;
    @(negedge clk);
    m8.start = 1'b0;
    repeat (3) begin @(negedge clk); lat++; end
    m8.a = 8'hFF; m8.b = 8'hFF; m8.cin = 1'b1; m8.start = 1'b1;
    @(negedge clk);
    lat++;
    m8.start = 1'b0;
    while (!m8.done && lat < 40) begin @(negedge clk); lat++; end
    vec++;
    if (lat !== 8) begin bad++; $display("FAIL ignored_start_latency got %0d want 8", lat); end
    vec++;
    if ({m8.sum, m8.cout, m8.ovf} !== {8'h33, 1'b0, 1'b0}) begin
      bad++; $display("FAIL ignored_start_result got sum=%h cout=%b ovf=%b want sum=33 cout=0 ovf=0", m8.sum, m8.cout, m8.ovf);
    end
    @(negedge clk);
    vec++;
    if ({m8.busy, m8.done} !== 2'b00) begin
      bad++; $display("FAIL ignored_start_idle got busy/done=%b want 00", {m8.busy, m8.done});
    end
  endtask

  task automatic test_reset_mid;
    int lat, bc, seen = 0;
    op8(8'hF0, 8'h20, 1'b0, lat, bc);
    vec++;
    if ({m8.sum, m8.cout, m8.ovf} !== {8'h10, 1'b1, 1'b0}) begin
      bad++; $display("FAIL pre_reset_result got sum=%h cout=%b ovf=%b want sum=10 cout=1 ovf=0", m8.sum, m8.cout, m8.ovf);
    end
    m8.a = 8'h7F; m8.b = 8'h7F; m8.cin = 1'b1; m8.start = 1'b1;
    @(negedge clk);
    m8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    vec++;
    if ({m8.busy, m8.done, m8.cout, m8.ovf, m8.sum} !== 12'h0) begin
      bad++; $display("FAIL reset_mid_outputs got %h want 000", {m8.busy, m8.done, m8.cout, m8.ovf, m8.sum});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) begin @(negedge clk); if (m8.done) seen++; end
    vec++;
    if (seen !== 0) begin bad++; $display("FAIL reset_mid_no_done got %0d pulses want 0", seen); end
    op8(8'h33, 8'h44, 1'b1, lat, bc);
    vec++;
    if ({lat[7:0], m8.sum, m8.cout, m8.ovf} !== {8'd8, 8'h78, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_mid_restart got lat=%0d sum=%h cout=%b ovf=%b want lat=8 sum=78 cout=0 ovf=0", lat, m8.sum, m8.cout, m8.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_sub;
`ifdef SERIAL_ADDER_SUB_EN
    int lat, bc;
    m8.sub = 1'b1;
    op8(8'h10, 8'h20, 1'b0, lat, bc);
    vec++;
    if ({m8.sum, m8.cout, m8.ovf} !== {8'hF0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL sub_10_20 got sum=%h cout=%b ovf=%b want sum=f0 cout=0 ovf=0", m8.sum, m8.cout, m8.ovf);
    end
    op8(8'h80, 8'h01, 1'b0, lat, bc);
    vec++;
    if ({m8.sum, m8.cout, m8.ovf} !== {8'h7F, 1'b1, 1'b1}) begin
      bad++; $display("FAIL sub_80_01 got sum=%h cout=%b ovf=%b want sum=7f cout=1 ovf=1", m8.sum, m8.cout, m8.ovf);
    end
    m8.sub = 1'b0;
    op8(8'h10, 8'h20, 1'b1, lat, bc);
    vec++;
    if ({m8.sum, m8.cout, m8.ovf} !== {8'h31, 1'b0, 1'b0}) begin
      bad++; $display("FAIL sub_off_add got sum=%h cout=%b ovf=%b want sum=31 cout=0 ovf=0", m8.sum, m8.cout, m8.ovf);
    end
    @(negedge clk);
`endif
  endtask

  task automatic test_width2;
    int lat;
    op2(2'd3, 2'd2, 1'b1, lat);
    vec++;
    if ({lat[7:0], m2.sum, m2.cout, m2.ovf} !== {8'd2, 2'd2, 1'b1, 1'b0}) begin
      bad++; $display("FAIL w2_3_2_1 got lat=%0d sum=%h cout=%b ovf=%b want lat=2 sum=2 cout=1 ovf=0", lat, m2.sum, m2.cout, m2.ovf);
    end
    op2(2'd1, 2'd1, 1'b0, lat);
    vec++;
    if ({lat[7:0], m2.sum, m2.cout, m2.ovf} !== {8'd2, 2'd2, 1'b0, 1'b1}) begin
      bad++; $display("FAIL w2_1_1_0 got lat=%0d sum=%h cout=%b ovf=%b want lat=2 sum=2 cout=0 ovf=1", lat, m2.sum, m2.cout, m2.ovf);
    end
    @(negedge clk);
  endtask

  task automatic test_width16;
    int lat;
    op16(16'h7FFF, 16'h0001, 1'b0, lat);
    vec++;
    if ({lat[7:0], m16.sum, m16.cout, m16.ovf} !== {8'd16, 16'h8000, 1'b0, 1'b1}) begin
      bad++; $display("FAIL w16_7fff_1 got lat=%0d sum=%h cout=%b ovf=%b want lat=16 sum=8000 cout=0 ovf=1", lat, m16.sum, m16.cout, m16.ovf);
    end
    op16(16'hFFFF, 16'hFFFF, 1'b1, lat);
    vec++;
    if ({m16.sum, m16.cout, m16.ovf} !== {16'hFFFF, 1'b1, 1'b0}) begin
      bad++; $display("FAIL w16_ffff_ffff got sum=%h cout=%b ovf=%b want sum=ffff cout=1 ovf=0", m16.sum, m16.cout, m16.ovf);
    end
    op16(16'h1234, 16'h4321, 1'b1, lat);
    vec++;
    if ({m16.sum, m16.cout, m16.ovf} !== {16'h5556, 1'b0, 1'b0}) begin
      bad++; $display("FAIL w16_1234_4321 got sum=%h cout=%b ovf=%b want sum=5556 cout=0 ovf=0", m16.sum, m16.cout, m16.ovf);
    end
    @(negedge clk);
  endtask

  initial begin
    m8.start = 1'b0; m8.a = '0; m8.b = '0; m8.cin = 1'b0;
    m2.start = 1'b0; m2.a = '0; m2.b = '0; m2.cin = 1'b0;
    m16.start = 1'b0; m16.a = '0; m16.b = '0; m16.cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    m8.sub = 1'b0; m2.sub = 1'b0; m16.sub = 1'b0;
`endif
    test_reset;
    test_basic;
    test_wrap;
    test_back_to_back;
    test_ignored_start;
    test_reset_mid;
    test_sub;
    test_width2;
    test_width16;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
